weight_cache_pp: RTL and testbench

Parametrised ping-pong weight buffer feeding the systolic array. It captures a weight matrix from an AXI-Stream-style input into one of two RAM banks and replays it word-by-word to the array, once per consumer read request, for a programmable number of passes. While one bank is being read, the next layer's weights load into the other bank, and the banks swap without a bubble. It sits between the weight DMA stream and the array, alongside the Img2Col activation streamer, which issues `raddr_valid`.

---
 rtl/wcache_pkg.sv | 29 ++
 rtl/wcache_bank.sv | 27 ++
 rtl/weight_cache_pp.sv | 239 +++++++++++++++++++++++
 tb/tb_weight_cache_pp.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wcache_pkg.sv
// wcache_pkg: shared types and constants for the weight_cache_pp slice.
//   - loader / reader state enums
//   - default geometry constants
//   - words_per_row(): ceiling divide of a column count by the bytes per word
package wcache_pkg;

  localparam int unsigned WC_DATA_W = 64;
  localparam int unsigned WC_ADDR_W = 12;
  localparam int unsigned WC_DIM_W  = 16;
  localparam int unsigned WC_REP_W  = 20;

  typedef enum logic [1:0] {
    L_IDLE,
    L_CALC,
    L_LOAD
  } ld_state_t;

  typedef enum logic {
    R_IDLE,
    R_RUN
  } rd_state_t;

  // bytes is a constant power of two at every call site, so this reduces to a shift.
  function automatic logic [31:0] words_per_row(input logic [31:0] cols,
                                                input logic [31:0] bytes);
    return (cols + bytes - 32'd1) / bytes;
  endfunction

endpackage

// File: rtl/wcache_bank.sv
// wcache_bank: simple dual-port RAM, one write port, one registered read port.
//   clk    : clock
//   we     : write enable, waddr/wdata : write address / data
//   re     : read enable, raddr : read address
//   rdata  : read data, valid the cycle after re; holds otherwise
// Contents are not reset.
module wcache_bank #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/weight_cache_pp.sv
// weight_cache_pp: ping-pong weight buffer feeding the systolic array.
// Captures a weight matrix from a valid/ready stream into a free bank, then
// replays it word by word on raddr_valid for rep_num passes. With
// WCACHE_PINGPONG_EN defined, two banks let the next set load during reads
// and swap in without a bubble; otherwise a single bank is used.
// Ports:
//   clk, reset (async, active-low)
//   start, matrix_row, matrix_col, rep_num : load request and geometry
//   s_data_valid / s_data_ready / s_data_payload : weight input stream
//   raddr_valid : consumer request for the next word
//   w_valid, w_data, w_last : weight output (1-cycle read latency)
//   weight_cached : active bank holds a complete set
//   layer_done : pulse with the final word of the final pass
//   cfg_err    : pulse when a start is rejected for bad geometry
module weight_cache_pp
  import wcache_pkg::*;
#(
  parameter int unsigned DATA_W = WC_DATA_W,
  parameter int unsigned ADDR_W = WC_ADDR_W,
  parameter int unsigned DIM_W  = WC_DIM_W,
  parameter int unsigned REP_W  = WC_REP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  matrix_row,
  input  logic [DIM_W-1:0]  matrix_col,
  input  logic [REP_W-1:0]  rep_num,
  input  logic              s_data_valid,
  output logic              s_data_ready,
  input  logic [DATA_W-1:0] s_data_payload,
  input  logic              raddr_valid,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  output logic              weight_cached,
  output logic              layer_done,
  output logic              cfg_err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned PW    = 2 * DIM_W;
  localparam logic [PW-1:0] MAX_WORDS = PW'(2**ADDR_W);
`ifdef WCACHE_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  ld_state_t l_state, l_next;
  rd_state_t r_state, r_next;

  // loader registers
  logic [DIM_W-1:0]  ld_row, ld_col;
  logic [REP_W-1:0]  ld_rep;
  logic              ld_bank;
  logic [ADDR_W-1:0] wr_addr;

  // per-bank geometry, written only while that bank is being loaded
  logic [ADDR_W-1:0] bank_last [2];
  logic [REP_W-1:0]  bank_rep  [2];
  logic [1:0]        bank_full;

  // reader registers
  logic              act_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [REP_W-1:0]  pass_cnt;
  logic              rd_sel_q;
  logic [DATA_W-1:0] rd_q [2];

  logic [1:0]        bank_active, bank_free, avail, take;
  logic [DIM_W-1:0]  wpr;
  logic [PW-1:0]     prod;
  logic              geo_bad, start_ok, wr_fire, ld_done;
  logic              rd_fire, at_last, at_final, layer_end, swap_ok;
  logic              take_idle, idle_pick;
  logic [1:0]        bank_we, bank_re;

  // ---------------- shared combinational decode ----------------
  always_comb begin
    bank_active[0] = (r_state == R_RUN) && !act_bank;
    bank_active[1] = (r_state == R_RUN) &&  act_bank;
    bank_free[0]   = !bank_full[0] && !bank_active[0];
    bank_free[1]   = PP && !bank_full[1] && !bank_active[1];
    start_ok       = start && (l_state == L_IDLE) && (|bank_free);

    wpr     = DIM_W'(words_per_row(32'(ld_col), 32'(BYTES)));
    prod    = PW'(ld_row) * PW'(wpr);
    geo_bad = (prod == '0) || (prod > MAX_WORDS);

    wr_fire = (l_state == L_LOAD) && s_data_valid;
    ld_done = wr_fire && (wr_addr == bank_last[ld_bank]);

    // A bank finishing its load this cycle is already eligible, so the reader
    // can claim it on the same edge (cached the cycle after the last handshake,
    // and a same-cycle layer end swaps straight onto it).
    avail[0] = bank_full[0] || (ld_done && !ld_bank);
    avail[1] = bank_full[1] || (ld_done &&  ld_bank);

    rd_fire   = (r_state == R_RUN) && raddr_valid;
    at_last   = (rd_addr == bank_last[act_bank]);
    at_final  = (pass_cnt == bank_rep[act_bank] - REP_W'(1));
    layer_end = rd_fire && at_last && at_final;
    swap_ok   = act_bank ? avail[0] : avail[1];

    take_idle = (r_state == R_IDLE) && (|avail);
    idle_pick = !avail[0];
    take[0]   = (take_idle && !idle_pick) || (layer_end && swap_ok &&  act_bank);
    take[1]   = (take_idle &&  idle_pick) || (layer_end && swap_ok && !act_bank);
  end

  // ---------------- loader FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) l_state <= L_IDLE;
    else        l_state <= l_next;
  end

  always_comb begin
    l_next = l_state;
    unique case (l_state)
      L_IDLE: if (start_ok) l_next = L_CALC;
      L_CALC: l_next = geo_bad ? L_IDLE : L_LOAD;
      L_LOAD: if (ld_done) l_next = L_IDLE;
      default: l_next = L_IDLE;
    endcase
  end

  always_comb begin
    s_data_ready = (l_state == L_LOAD);
    cfg_err      = (l_state == L_CALC) && geo_bad;
    bank_we[0]   = wr_fire && !ld_bank;
    bank_we[1]   = wr_fire &&  ld_bank;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_row    <= '0;
      ld_col    <= '0;
      ld_rep    <= '0;
      ld_bank   <= 1'b0;
      wr_addr   <= '0;
      bank_last <= '{default: '0};
      bank_rep  <= '{default: '0};
      bank_full <= '0;
    end else begin
      if (start_ok) begin
        ld_row  <= matrix_row;
        ld_col  <= matrix_col;
        ld_rep  <= (rep_num == '0) ? REP_W'(1) : rep_num;
        ld_bank <= !bank_free[0];
        wr_addr <= '0;
      end
      if ((l_state == L_CALC) && !geo_bad) begin
        bank_last[ld_bank] <= ADDR_W'(prod - PW'(1));
        bank_rep[ld_bank]  <= ld_rep;
      end
      if (wr_fire) wr_addr <= wr_addr + ADDR_W'(1);
      bank_full <= avail & ~take;
    end
  end

  // ---------------- reader FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (take_idle) r_next = R_RUN;
      R_RUN:  if (layer_end && !swap_ok) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    weight_cached = (r_state == R_RUN);
    bank_re[0]    = rd_fire && !act_bank;
    bank_re[1]    = rd_fire &&  act_bank;
    w_data        = w_valid ? rd_q[rd_sel_q] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_bank   <= 1'b0;
      rd_addr    <= '0;
      pass_cnt   <= '0;
      rd_sel_q   <= 1'b0;
      w_valid    <= 1'b0;
      w_last     <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      w_valid    <= rd_fire;
      w_last     <= rd_fire && at_last;
      layer_done <= layer_end;
      if (rd_fire) rd_sel_q <= act_bank;
      if (take_idle) begin
        act_bank <= idle_pick;
        rd_addr  <= '0;
        pass_cnt <= '0;
      end else if (rd_fire) begin
        if (at_last) begin
          rd_addr  <= '0;
          pass_cnt <= layer_end ? '0 : pass_cnt + REP_W'(1);
          if (layer_end && swap_ok) act_bank <= !act_bank;
        end else begin
          rd_addr <= rd_addr + ADDR_W'(1);
        end
      end
    end
  end

  // ---------------- banks ----------------
  wcache_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (clk),
    .we    (bank_we[0]),
    .waddr (wr_addr),
    .wdata (s_data_payload),
    .re    (bank_re[0]),
    .raddr (rd_addr),
    .rdata (rd_q[0])
  );

`ifdef WCACHE_PINGPONG_EN
  wcache_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (clk),
    .we    (bank_we[1]),
    .waddr (wr_addr),
    .wdata (s_data_payload),
    .re    (bank_re[1]),
    .raddr (rd_addr),
    .rdata (rd_q[1])
  );
`else
  assign rd_q[1] = '0;
`endif

endmodule

// File: tb/tb_weight_cache_pp.sv
// tb_weight_cache_pp: directed self-checking bench for weight_cache_pp.
module tb_weight_cache_pp;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DIM_W  = 16;
  localparam int unsigned REP_W  = 20;

  localparam logic [63:0] B1 = 64'h1111_0000_0000_0000;
  localparam logic [63:0] B2 = 64'h0000_0000_0000_00A0;
  localparam logic [63:0] B5 = 64'h5500_0000_0000_0000;
  localparam logic [63:0] B6 = 64'h6600_0000_0000_0000;
  localparam logic [63:0] B7 = 64'h7700_0000_0000_0000;
  localparam logic [63:0] B8 = 64'h8800_0000_0000_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  matrix_row = '0;
  logic [DIM_W-1:0]  matrix_col = '0;
  logic [REP_W-1:0]  rep_num = '0;
  logic              s_data_valid = 1'b0;
  logic              s_data_ready;
  logic [DATA_W-1:0] s_data_payload = '0;
  logic              raddr_valid = 1'b0;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_last;
  logic              weight_cached;
  logic              layer_done;
  logic              cfg_err;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  logic [DATA_W+1:0] got_q [$];
  logic [DATA_W+1:0] exp_q [$];
  logic              rv_q = 1'b0;
  int unsigned       spurious = 0;
  int unsigned       drops = 0;
  bit                watch_cached = 1'b0;

  weight_cache_pp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .REP_W(REP_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .matrix_row(matrix_row), .matrix_col(matrix_col), .rep_num(rep_num),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
    .s_data_payload(s_data_payload), .raddr_valid(raddr_valid),
    .w_valid(w_valid), .w_data(w_data), .w_last(w_last),
    .weight_cached(weight_cached), .layer_done(layer_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  // output capture: every w_valid must follow a raddr_valid on the prior edge
  always @(posedge clk) rv_q <= raddr_valid;
  always @(negedge clk) begin
    if (w_valid) begin
      got_q.push_back({layer_done, w_last, w_data});
      if (!rv_q) spurious++;
    end else if (layer_done || w_last) begin
      spurious++;
    end
    if (watch_cached && !weight_cached && (got_q.size() < exp_q.size())) drops++;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkw(input logic [63:0] base, input int unsigned i);
    return base + 64'(i);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0; s_data_valid = 1'b0; raddr_valid = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic do_start(input int unsigned row, input int unsigned col, input int unsigned rep);
    matrix_row = DIM_W'(row);
    matrix_col = DIM_W'(col);
    rep_num    = REP_W'(rep);
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  task automatic load_words(input logic [63:0] base, input int unsigned n, input bit toggle);
    int unsigned idx = 0;
    int unsigned k = 0;
    bit hs;
    while (idx < n && k < 20000) begin
      s_data_valid   = toggle ? (k % 2 == 0) : 1'b1;
      s_data_payload = mkw(base, idx);
      hs = s_data_valid && s_data_ready;
      cyc();
      if (hs) idx++;
      k++;
    end
    s_data_valid = 1'b0;
    chk("load_accepts", idx, n);
  endtask

  task automatic add_exp(input logic [63:0] base, input int unsigned w, input int unsigned r);
    for (int unsigned p = 0; p < r; p++)
      for (int unsigned i = 0; i < w; i++)
        exp_q.push_back({(i == w - 1) && (p == r - 1), (i == w - 1), mkw(base, i)});
  endtask

  task automatic read_all(input bit toggle, input int unsigned budget);
    int unsigned k = 0;
    while (got_q.size() < exp_q.size() && k < budget) begin
      raddr_valid = toggle ? (k % 2 == 1) : 1'b1;
      k++;
      cyc();
    end
    raddr_valid = 1'b0;
    repeat (2) cyc();
    chk("read_in_budget", (k < budget), 1);
    // requests while nothing is cached must be ignored
    raddr_valid = 1'b1;
    repeat (4) cyc();
    raddr_valid = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic cmp_stream(input string tag);
    int unsigned errs = 0;
    int unsigned dones = 0;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i][DATA_W+1]) dones++;
      if (got_q[i] !== exp_q[i]) begin
        if (errs == 0) chk({tag, "_first_bad_word"}, got_q[i], exp_q[i]);
        errs++;
      end
    end
    chk({tag, "_word_errs"}, errs, 0);
    chk({tag, "_spurious"}, spurious, 0);
  endtask

  task automatic clear_stream();
    got_q.delete();
    exp_q.delete();
    spurious = 0;
    drops = 0;
  endtask

  initial begin
    // ---- reset state ----
    reset = 1'b0;
    #1;
    chk("rst_ready", s_data_ready, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_cached", weight_cached, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    do_reset();

    // ---- rejected geometry ----
    do_start(0, 32, 1);
    chk("row0_cfg_err", cfg_err, 1);
    cyc();
    chk("row0_cfg_err_pulse", cfg_err, 0);
    chk("row0_ready", s_data_ready, 0);
    cyc();
    chk("row0_ready_late", s_data_ready, 0);

    do_start(4097, 8, 1);
    chk("over_cfg_err", cfg_err, 1);
    cyc();
    chk("over_cfg_err_pulse", cfg_err, 0);
    chk("over_ready", s_data_ready, 0);

    // exactly 2^ADDR_W words is legal
    do_start(512, 64, 1);
    chk("full_depth_cfg_err", cfg_err, 0);
    cyc();
    chk("full_depth_ready", s_data_ready, 1);
    do_reset();

    // ---- 288x32, two passes, second set overlapping ----
    clear_stream();
    do_start(288, 32, 2);
    chk("calc_ready_low", s_data_ready, 0);
    cyc();
    chk("load_ready_2cyc", s_data_ready, 1);
    load_words(B1, 1152, 1'b0);
    chk("cached_after_load", weight_cached, 1);
    chk("ready_after_load", s_data_ready, 0);

    raddr_valid = 1'b1;
    cyc();
    raddr_valid = 1'b0;
    chk("first_w_valid", w_valid, 1);
    chk("first_w_data", w_data, mkw(B1, 0));
    chk("first_w_last", w_last, 0);
    cyc();
    chk("idle_w_valid", w_valid, 0);

    add_exp(B1, 1152, 2);
`ifdef WCACHE_PINGPONG_EN
    add_exp(B2, 3, 1);
`endif
    watch_cached = 1'b1;
    fork
      read_all(1'b0, 8000);
      begin
        repeat (40) cyc();
`ifdef WCACHE_PINGPONG_EN
        do_start(3, 8, 1);
        load_words(B2, 3, 1'b0);
`else
        do_start(6, 8, 1);
        chk("busy_start_cfg_err", cfg_err, 0);
        for (int i = 0; i < 3; i++) begin
          cyc();
          chk("busy_start_ignored", s_data_ready, 0);
        end
`endif
      end
    join
    watch_cached = 1'b0;
    cmp_stream("layer1");
    chk("layer1_cached_drops", drops, 0);
    chk("layer1_cached_end", weight_cached, 0);
    chk("last_pass1_pos", got_q[1151][DATA_W+1:DATA_W], 2'b01);
    chk("last_pass2_pos", got_q[2303][DATA_W+1:DATA_W], 2'b11);

    // ---- toggled valid on load and read ----
    clear_stream();
    do_start(5, 16, 3);
    load_words(B5, 10, 1'b1);
    chk("toggle_cached", weight_cached, 1);
    add_exp(B5, 10, 3);
    read_all(1'b1, 1000);
    cmp_stream("toggle");

    // ---- rep_num 0 acts as a single pass ----
    clear_stream();
    do_start(2, 8, 0);
    load_words(B8, 2, 1'b0);
    add_exp(B8, 2, 1);
    read_all(1'b0, 100);
    cmp_stream("rep0");

    // ---- reset mid-load ----
    clear_stream();
    do_start(288, 32, 1);
    load_words(B6, 500, 1'b0);
    chk("midload_ready", s_data_ready, 1);
    reset = 1'b0;
    #1;
    chk("abort_ready", s_data_ready, 0);
    chk("abort_w_valid", w_valid, 0);
    chk("abort_w_data", w_data, 0);
    chk("abort_w_last", w_last, 0);
    chk("abort_cached", weight_cached, 0);
    chk("abort_layer_done", layer_done, 0);
    chk("abort_cfg_err", cfg_err, 0);
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    chk("no_auto_restart", s_data_ready, 0);

    do_start(288, 32, 1);
    load_words(B7, 1152, 1'b0);
    chk("reload_cached", weight_cached, 1);
    add_exp(B7, 1152, 1);
    read_all(1'b0, 3000);
    cmp_stream("reload");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
